// File: rtl/rr_arbiter_pkg.sv
// Shared defaults and state type for the round-robin binary-grant arbiter.
package rr_arbiter_pkg;

  localparam int unsigned NumReqDefault = 16;
  localparam int unsigned BinWDefault   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at NUM_REQ.
module rr_pick
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = NumReqDefault,
  parameter int unsigned BIN_W   = BinWDefault
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [BIN_W-1:0]   ptr,
  output logic               any,
  output logic [BIN_W-1:0]   idx
);

  localparam int unsigned Span = 2 ** BIN_W;

  logic [Span-1:0] req_ext;
  logic [BIN_W:0]  cand;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req;
    any                  = 1'b0;
    idx                  = '0;
    cand                 = '0;
    // Walk offsets from ptr; the extra bit of cand catches the wrap past NUM_REQ-1.
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (BIN_W+1)'(k);
      if (cand >= (BIN_W+1)'(NUM_REQ)) begin
        cand = cand - (BIN_W+1)'(NUM_REQ);
      end
      if (!any && req_ext[cand[BIN_W-1:0]]) begin
        any = 1'b1;
        idx = cand[BIN_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_bin.sv
// Round-robin arbiter with registered binary grant and valid/ready handshake.
// Optional lock_i (holds the priority pointer on handshake) when RR_ARBITER_LOCK_EN is defined.
module rr_arbiter_bin
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = NumReqDefault,
  parameter int unsigned BIN_W   = BinWDefault
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
`ifdef RR_ARBITER_LOCK_EN
  input  logic               lock_i,
`endif
  input  logic               gnt_ready_i,
  output logic               gnt_valid_o,
  output logic [BIN_W-1:0]   gnt_bin_o
);

  state_e           state_q;
  logic [BIN_W-1:0] gnt_bin_q;
  logic [BIN_W-1:0] ptr_q;
  logic [BIN_W-1:0] ptr_inc;
  logic [BIN_W-1:0] ptr_hs;
  logic [BIN_W-1:0] pick_ptr;
  logic [BIN_W-1:0] pick_idx;
  logic             pick_any;
  logic             hs;

  assign hs      = (state_q == GRANT) && gnt_ready_i;
  assign ptr_inc = (gnt_bin_q == BIN_W'(NUM_REQ - 1)) ? '0 : gnt_bin_q + BIN_W'(1);

`ifdef RR_ARBITER_LOCK_EN
  assign ptr_hs = lock_i ? ptr_q : ptr_inc;
`else
  assign ptr_hs = ptr_inc;
`endif

  // On a handshake the next winner is chosen with the already-advanced pointer.
  assign pick_ptr = hs ? ptr_hs : ptr_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .BIN_W   (BIN_W)
  ) u_pick (
    .req (req_i),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_bin_q <= '0;
      ptr_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            gnt_bin_q <= pick_idx;
            state_q   <= GRANT;
          end
        end
        GRANT: begin
          if (gnt_ready_i) begin
            ptr_q <= ptr_hs;
            if (pick_any) begin
              gnt_bin_q <= pick_idx;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_valid_o = (state_q == GRANT);
  assign gnt_bin_o   = gnt_bin_q;

endmodule

// File: tb/tb_rr_arbiter_bin.sv
// Self-checking bench for rr_arbiter_bin: directed vector table, lock sequence
// (when RR_ARBITER_LOCK_EN is defined) and randomized traffic against a reference model.
module tb_rr_arbiter_bin;

  localparam int unsigned N = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic         ready;
  logic         lock;
  logic         gnt_valid;
  logic [3:0]   gnt_bin;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_arbiter_bin dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req),
`ifdef RR_ARBITER_LOCK_EN
    .lock_i      (lock),
`endif
    .gnt_ready_i (ready),
    .gnt_valid_o (gnt_valid),
    .gnt_bin_o   (gnt_bin)
  );

  typedef struct {
    logic         rst;
    logic [N-1:0] rq;
    logic         rdy;
    logic         exp_v;
    logic         chk_b;
    logic [3:0]   exp_b;
  } vec_t;

  vec_t tbl[$];

  // Reference model state
  bit m_valid;
  bit m_known;
  int m_bin;
  int m_ptr;

  // Fairness bookkeeping: handshakes seen by each continuously requesting index
  int waitc[N];
  int max_wait;

  function automatic int pick(input logic [N-1:0] r, input int p);
    int j;
    for (int k = 0; k < int'(N); k++) begin
      j = (p + k) % int'(N);
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_step();
    int w;
    if (reset) begin
      m_valid = 1'b0;
      m_bin   = 0;
      m_ptr   = 0;
      m_known = 1'b1;
    end else if (!m_valid) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin
        m_valid = 1'b1;
        m_bin   = w;
        m_known = 1'b1;
      end
    end else if (ready) begin
      if (!lock) m_ptr = (m_bin + 1) % int'(N);
      w = pick(req, m_ptr);
      if (w >= 0) begin
        m_bin = w;
      end else begin
        m_valid = 1'b0;
        m_known = 1'b0;
      end
    end
  endtask

  task automatic fair_step();
    bit hs_obs;
    hs_obs = gnt_valid && ready;
    for (int i = 0; i < int'(N); i++) begin
      if (reset || !req[i]) begin
        waitc[i] = 0;
      end else if (hs_obs) begin
        if (int'(gnt_bin) == i) waitc[i] = 0;
        else waitc[i] = waitc[i] + 1;
        if (waitc[i] > max_wait) max_wait = waitc[i];
      end
    end
  endtask

  // Advance one clock with the inputs currently driven; sample 1 ns after the edge.
  task automatic cycle();
    fair_step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic ev, input logic cb, input logic [3:0] eb);
    n_cmp++;
    if (gnt_valid !== ev || (cb && gnt_bin !== eb)) begin
      n_err++;
      $display("FAIL %s: got valid=%0b bin=%0d, want valid=%0b bin=%0d%s", name, gnt_valid,
               gnt_bin, ev, eb, cb ? "" : " (bin not checked)");
    end
  endtask

  task automatic add(input logic rst, input logic [N-1:0] rq, input logic rdy, input logic ev,
                     input logic cb, input logic [3:0] eb);
    vec_t v;
    v.rst = rst; v.rq = rq; v.rdy = rdy; v.exp_v = ev; v.chk_b = cb; v.exp_b = eb;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic [N-1:0] rq, input logic rdy, input logic lk);
    reset = rst;
    req   = rq;
    ready = rdy;
    lock  = lk;
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    ready = 1'b0;
    lock  = 1'b0;
    max_wait = 0;
    foreach (waitc[i]) waitc[i] = 0;

    // Reset, then idle with ready high (ignored while idle)
    add(1, 16'h0000, 0, 0, 1, 4'd0);
    for (int i = 0; i < 5; i++) add(0, 16'h0000, 1, 0, 1, 4'd0);
    // Two requesters alternate with ready held high
    add(0, 16'h0011, 1, 1, 1, 4'd0);
    add(0, 16'h0011, 1, 1, 1, 4'd4);
    add(0, 16'h0011, 1, 1, 1, 4'd0);
    add(0, 16'h0011, 1, 1, 1, 4'd4);
    add(0, 16'h0000, 1, 0, 0, 4'd0);
    // Grant to 3 held while request drops and ready stays low
    add(0, 16'h0008, 0, 1, 1, 4'd3);
    for (int i = 0; i < 4; i++) add(0, 16'h0000, 0, 1, 1, 4'd3);
    add(0, 16'h0000, 1, 0, 0, 4'd0);
    add(0, 16'h0000, 0, 0, 0, 4'd0);
    // Pointer at 15 after grant to 14, then wrap to 0
    add(0, 16'h4000, 0, 1, 1, 4'd14);
    add(0, 16'hC001, 1, 1, 1, 4'd15);
    add(0, 16'hC001, 1, 1, 1, 4'd0);
    add(0, 16'hC001, 1, 1, 1, 4'd14);
    // Reset during a live handshake wins; pointer restarts at 0
    add(1, 16'hFFFF, 1, 0, 1, 4'd0);
    add(0, 16'hFFFF, 0, 1, 1, 4'd0);
    add(0, 16'hFFFF, 1, 1, 1, 4'd1);
    add(0, 16'hFFFF, 1, 1, 1, 4'd2);
    add(0, 16'h0000, 1, 0, 0, 4'd0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].rq, tbl[i].rdy, 1'b0);
      cycle();
      check($sformatf("vec%0d", i), tbl[i].exp_v, tbl[i].chk_b, tbl[i].exp_b);
    end

`ifdef RR_ARBITER_LOCK_EN
    drive(1, 16'h0000, 0, 0); cycle(); check("lock_reset", 0, 1, 4'd0);
    drive(0, 16'h0006, 0, 1); cycle(); check("lock_first", 1, 1, 4'd1);
    drive(0, 16'h0006, 1, 1); cycle(); check("lock_hold1", 1, 1, 4'd1);
    drive(0, 16'h0006, 1, 1); cycle(); check("lock_hold2", 1, 1, 4'd1);
    drive(0, 16'h0006, 1, 0); cycle(); check("lock_release", 1, 1, 4'd2);
    drive(0, 16'h0000, 1, 0); cycle(); check("lock_drain", 0, 0, 4'd0);
`endif

    // Randomized traffic: sticky requests, bursty ready, rare resets
    drive(1, 16'h0000, 0, 0);
    cycle();
    check("rand_reset", 0, 1, 4'd0);
    foreach (waitc[i]) waitc[i] = 0;
    max_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] nr;
      nr = req;
      for (int b = 0; b < int'(N); b++) if ($urandom_range(7) == 0) nr[b] = ~nr[b];
      drive(($urandom_range(199) == 0), nr, ($urandom_range(3) != 0), 1'b0);
      cycle();
      check($sformatf("rand%0d", c), m_valid, m_valid || m_known, 4'(m_bin));
    end

    n_cmp++;
    if (max_wait > int'(N) - 1) begin
      n_err++;
      $display("FAIL fairness: got max_wait=%0d, want <= %0d", max_wait, N - 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_bin.md
RR_ARBITER_BIN -- requirements
Module: rr_arbiter_bin

Interface
REQ-001 SHALL have parameter NUM_REQ, default 16, meaning the number of requesters, legal range 2..2**BIN_W.
REQ-002 SHALL have parameter BIN_W, default 4, meaning the width of the binary grant index (sized for a downstream binary-to-one-hot decoder).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_i  input  NUM_REQ  level-sensitive request per requester.
REQ-006 SHALL have port gnt_valid_o  output  1  a registered grant is presented.
REQ-007 SHALL have port gnt_bin_o  output  BIN_W  registered binary index of the granted requester.
REQ-008 SHALL have port gnt_ready_i  input  1  the consumer accepts the grant this cycle.

Function
REQ-009 SHALL implement two states: IDLE (gnt_valid_o=0) and GRANT (gnt_valid_o=1).
REQ-010 SHALL hold a priority pointer ptr (BIN_W bits) naming the highest-priority requester.
REQ-011 SHALL, in IDLE with any req_i bit set, select the first set bit at index ptr, ptr+1, ... with wrap from NUM_REQ-1 to 0, register it into gnt_bin_o, and enter GRANT on the next edge (1-cycle request-to-valid latency).
REQ-012 SHALL, in IDLE with req_i all zero, remain in IDLE with gnt_bin_o unchanged.
REQ-013 SHALL, in GRANT with gnt_ready_i=0, hold gnt_valid_o and gnt_bin_o stable, even if the granted req_i bit drops (no grant retraction).
REQ-014 SHALL, on handshake (gnt_valid_o & gnt_ready_i), set ptr to gnt_bin_o+1, wrapping NUM_REQ-1 to 0.
REQ-015 SHALL, on handshake, arbitrate among that cycle's req_i using the updated pointer: if any bit is set, load the new winner and stay in GRANT (back-to-back, one grant per cycle); otherwise go to IDLE.
REQ-016 SHALL regard req_i bits at index >= NUM_REQ as non-existent and never grant them.
REQ-017 SHALL guarantee that every continuously asserting requester is granted within NUM_REQ handshakes.
REQ-018 SHALL ignore gnt_ready_i while in IDLE.

Reset
REQ-019 SHALL, on reset high at a clock edge, set the state to IDLE, gnt_valid_o to 0, gnt_bin_o to 0 and ptr to 0, aborting any presented grant.
REQ-020 SHALL give reset priority over handshake and arbitration occurring in the same cycle.

Configuration
REQ-021 SHALL support macro RR_ARBITER_LOCK_EN. When it is defined, the block adds input lock_i (1 bit). A handshake with lock_i=1 leaves ptr unchanged, so the same requester wins again if it is still requesting. When the macro is undefined, lock_i is absent and REQ-014 always applies.

Structure
REQ-022 SHALL place NUM_REQ/BIN_W defaults and the state enum (IDLE, GRANT) in shared package rr_arbiter_pkg.
REQ-023 SHALL implement the pointer-masked wraparound selection in sub-module rr_pick.
- rr_pick is purely combinational.
- Inputs: req, ptr.
- Outputs: any, idx.

Verification
REQ-024 SHALL cover the following directed scenarios:
- Reset, then req_i=16'h0000 for 5 cycles -> gnt_valid_o stays 0 and gnt_bin_o stays 0.
- req_i=16'h0011 with gnt_ready_i=1 held -> grants 0, 4, 0, 4 on consecutive cycles, first valid 1 cycle after req.
- req_i=16'h0008 with gnt_ready_i=0 for 4 cycles while req_i drops to 0 -> gnt_bin_o=3 held valid; on ready=1, handshake, then IDLE.
- ptr=15 (after a grant to 14), req_i=16'hC001 -> grant 15 first, then wrap to grant 0.
- Reset asserted while valid=1 and ready=1 -> next cycle gnt_valid_o=0 and ptr=0; req_i=16'hFFFF then yields grant 0.
- With RR_ARBITER_LOCK_EN defined: lock_i=1, req_i=16'h0006 -> grant 1 repeats each handshake; lock_i=0 -> next grant 2.
